// File: rtl/bullet_pool_fsm.sv
// bullet_pool_fsm
//   Multi-projectile pool for Megaman. NUM_BULLETS independent slots, each
//   with position, direction and live flag. All slot motion, spawning and
//   cooldown advance only on a frame tick derived from the sampled
//   vertical-sync clock. Collision pulses may arrive on any cycle and are
//   held as kill-pending until the next tick.
//
// Ports
//   Clk            in   system clock
//   RESET_N        in   synchronous active-low reset
//   frame_clk      in   vertical-sync frame clock (sampled, edge-detected)
//   shoot_key      in   fire key level
//   facing_right   in   shooter facing, 1 = right
//   shooter_x/y    in   shooter position (COORD_W)
//   collision      in   per-slot hit pulse (NUM_BULLETS)
//   bullet_x/y     out  packed slot positions, slot i at [i*COORD_W +: COORD_W]
//   bullet_active  out  per-slot live flag
//   bullet_dir     out  per-slot direction, 1 = right
//   active_count   out  number of live slots
//   fired          out  one-cycle pulse when a slot spawns
//   LEDR0          out  any slot live
module bullet_pool_fsm #(
  parameter int NUM_BULLETS = 4,
  parameter int COORD_W     = 10,
  parameter int SPEED       = 9,
  parameter int BULLET_W    = 10,
  parameter int SCREEN_MIN  = 2,
  parameter int SCREEN_MAX  = 639,
  parameter int MUZZLE_XR   = 60,
  parameter int MUZZLE_Y    = 22,
  parameter int COOLDOWN    = 4,
  parameter int AUTO_FIRE   = 0
) (
  input  logic                               Clk,
  input  logic                               RESET_N,
  input  logic                               frame_clk,
  input  logic                               shoot_key,
  input  logic                               facing_right,
  input  logic [COORD_W-1:0]                 shooter_x,
  input  logic [COORD_W-1:0]                 shooter_y,
  input  logic [NUM_BULLETS-1:0]             collision,
  output logic [NUM_BULLETS*COORD_W-1:0]     bullet_x,
  output logic [NUM_BULLETS*COORD_W-1:0]     bullet_y,
  output logic [NUM_BULLETS-1:0]             bullet_active,
  output logic [NUM_BULLETS-1:0]             bullet_dir,
  output logic [$clog2(NUM_BULLETS+1)-1:0]   active_count,
  output logic                               fired,
  output logic                               LEDR0
);

  localparam int CNT_W = $clog2(NUM_BULLETS + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  // Boundary math is done one bit wider than the coordinates so that
  // x + SPEED + BULLET_W cannot overflow and the left test never wraps.
  localparam logic [COORD_W:0]   SPEED_E = (COORD_W + 1)'(SPEED);
  localparam logic [COORD_W:0]   BW_E    = (COORD_W + 1)'(BULLET_W);
  localparam logic [COORD_W:0]   RLIM_E  = (COORD_W + 1)'(SCREEN_MAX);
  localparam logic [COORD_W:0]   LLIM_E  = (COORD_W + 1)'(SCREEN_MIN + SPEED);
  localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] MUZ_XR  = COORD_W'(MUZZLE_XR);
  localparam logic [COORD_W-1:0] MUZ_Y   = COORD_W'(MUZZLE_Y);
  localparam logic [CD_W-1:0]    CD_INIT = CD_W'(COOLDOWN);

  function automatic logic [CD_W-1:0] cd_step(input logic [CD_W-1:0] c);
    return (c == '0) ? c : c - CD_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_BULLETS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BULLETS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  logic [1:0]             fsync_q, fsync_d;
  logic [COORD_W-1:0]     x_q [NUM_BULLETS];
  logic [COORD_W-1:0]     x_d [NUM_BULLETS];
  logic [COORD_W-1:0]     y_q [NUM_BULLETS];
  logic [COORD_W-1:0]     y_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic [NUM_BULLETS-1:0] dir_q, dir_d;
  logic [NUM_BULLETS-1:0] pend_q, pend_d;
  logic [CD_W-1:0]        cd_q, cd_d;
  logic                   key_q, key_d;
  logic                   fired_q, fired_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   led_q, led_d;

  logic                   tick;
  logic                   req;
  logic                   spawn_ok;
  logic                   found;
  logic [NUM_BULLETS-1:0] kill;
  logic [COORD_W:0]       xe;

  always_comb begin
    fsync_d  = {fsync_q[0], frame_clk};
    tick     = fsync_q[0] & ~fsync_q[1];
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    dir_d    = dir_q;
    cd_d     = cd_q;
    key_d    = key_q;
    fired_d  = 1'b0;
    req      = 1'b0;
    spawn_ok = 1'b0;
    found    = 1'b0;
    xe       = '0;

    // A hit arriving on the tick cycle itself still kills at that tick.
    kill   = pend_q | (collision & active_q);
    pend_d = tick ? '0 : kill;

    if (tick) begin
      key_d = shoot_key;
      req   = (AUTO_FIRE != 0) ? shoot_key : (shoot_key & ~key_q);
      cd_d  = cd_step(cd_q);

      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (active_q[i]) begin
          xe = {1'b0, x_q[i]};
          if (kill[i]) begin
            active_d[i] = 1'b0;
          end else if (dir_q[i] && (xe + SPEED_E + BW_E > RLIM_E)) begin
            active_d[i] = 1'b0;
          end else if (!dir_q[i] && (xe < LLIM_E)) begin
            active_d[i] = 1'b0;
          end else begin
            x_d[i] = dir_q[i] ? x_q[i] + SPEED_C : x_q[i] - SPEED_C;
          end
        end
      end

      // Free slots are judged on pre-tick state, so a slot dying this tick
      // is not handed out until the following one.
      spawn_ok = req && (cd_q == '0) && (active_q != '1);
      if (spawn_ok) begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
          if (!active_q[i] && !found) begin
            found       = 1'b1;
            active_d[i] = 1'b1;
            dir_d[i]    = facing_right;
            x_d[i]      = facing_right ? shooter_x + MUZ_XR : shooter_x;
            y_d[i]      = shooter_y + MUZ_Y;
          end
        end
        cd_d    = CD_INIT;
        fired_d = 1'b1;
      end
    end

    count_d = popcount(active_d);
    led_d   = |active_d;
  end

  always_ff @(posedge Clk) begin
    if (!RESET_N) begin
      fsync_q  <= '0;
      active_q <= '0;
      dir_q    <= '0;
      pend_q   <= '0;
      cd_q     <= '0;
      key_q    <= 1'b0;
      fired_q  <= 1'b0;
      count_q  <= '0;
      led_q    <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      fsync_q  <= fsync_d;
      active_q <= active_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      cd_q     <= cd_d;
      key_q    <= key_d;
      fired_q  <= fired_d;
      count_q  <= count_d;
      led_q    <= led_d;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
    assign bullet_x[g*COORD_W +: COORD_W] = x_q[g];
    assign bullet_y[g*COORD_W +: COORD_W] = y_q[g];
  end

  assign bullet_active = active_q;
  assign bullet_dir    = dir_q;
  assign active_count  = count_q;
  assign fired         = fired_q;
  assign LEDR0         = led_q;

endmodule
